sampler_buffer_drain: RTL
=========================

Name: sampler_buffer_drain

Overview:
- Downstream consumer of the lease sampler's reuse-interval buffer.
- When the sampler buffer is full, or the host requests a flush, the block walks buffer addresses 0..N-1 and reads each record: PC address, interval, 64b trace and target tag.
- It serialises each record into 32b words on a valid/ready stream to the host comm path, then pulses the buffer-clear line. This unblocks the stalled cache and core.

Parameters:
- BUF_AW, 13, buffer address width (matches the sampler buffer).
- BUF_DEPTH, 8192, maximum records drained per pass.
- READ_LATENCY, 2, cycles from buf_addr_o change to valid buffer data (range 1..3).

Ports:
- clock_i  in  1  single clock, rising edge.
- resetn_i  in  1  asynchronous, active-low reset.
- enable_i  in  1  permits starting a drain.
- full_flag_i  in  1  sampler buffer-full level.
- flush_i  in  1  single-cycle host request to drain the current contents.
- used_i  in  32  number of valid records in the buffer.
- buf_addr_o  out  BUF_AW  buffer read address.
- ref_address_i  in  32  record PC.
- ref_interval_i  in  32  record reuse interval (negative = evicted/unfinished).
- ref_trace_i  in  64  record trace index.
- ref_target_i  in  32  record target tag.
- data_o  out  32  stream word.
- valid_o  out  1  stream word valid.
- ready_i  in  1  stream sink ready.
- last_o  out  1  final word of the pass.
- clear_o  out  1  one-cycle buffer-clear pulse.
- busy_o  out  1  high in any state other than IDLE.
- records_o  out  32  total records drained since reset, saturating at 32'hFFFFFFFF.

Behaviour:
- Reset values: all outputs 0, state IDLE, internal counters 0.
- Reset may assert at any time, including mid-pass. It aborts the pass and sends no clear_o.
- States: IDLE, ADDR, WAIT, SEND, CLEAR, RELEASE.
- IDLE:
  - Start condition: enable_i && (full_flag_i || flush_i). flush_i has no other effect in IDLE.
  - On start, latch N = min(used_i, BUF_DEPTH) and set the record index to 0.
  - If N==0, go to CLEAR; otherwise go to ADDR.
- ADDR: drive buf_addr_o = index, load the latency counter with READ_LATENCY, go to WAIT.
- WAIT:
  - Decrement the latency counter each cycle.
  - At 0, capture all four fields into a 160b holding register in one cycle, then go to SEND at word 0.
  - Buffer inputs are ignored outside this capture cycle.
- SEND: emit 5 words in order:
  - w0 = address
  - w1 = interval
  - w2 = trace[31:0]
  - w3 = trace[63:32]
  - w4 = target
- Stream handshake:
  - A word transfers when valid_o && ready_i.
  - Once valid_o rises, data_o, last_o and valid_o hold steady until the transfer. The block never retracts valid_o.
  - Back-to-back words are allowed: with ready_i held high, words go out in consecutive cycles.
  - valid_o drops on the cycle after w4 transfers.
- last_o: high only with w4 of record N-1.
- After w4 transfers:
  - Increment records_o.
  - If index==N-1, go to CLEAR; otherwise increment index and go to ADDR.
- Record latency: ADDR to first valid word = READ_LATENCY+2 cycles. Minimum per record = READ_LATENCY+7 cycles with ready_i held high.
- CLEAR: clear_o high for exactly one cycle, then go to RELEASE.
- RELEASE:
  - Wait until full_flag_i==0, then return to IDLE. This prevents re-triggering on a stale full level.
  - flush_i is ignored here.
- enable_i deassertion mid-pass does not abort; the pass completes including clear_o.
- flush_i while busy is ignored. It is not queued.
- used_i, full_flag_i and flush_i changing mid-pass have no effect on the latched N.
- Index width is BUF_AW+1, so N = BUF_DEPTH (8192) completes without wrap.
- busy_o = (state != IDLE).

Test Plan:
- Basic drain: used_i=3, full_flag_i rises, ready_i=1, record k = {addr 0x1000+4k, interval k+5, trace 0x0000000100000000+k, target 0xA0+k} → 15 words in order. last_o only on word 15. One clear_o pulse after the last word. records_o=3.
- Negative interval and backpressure: record interval 0xFFFFFFF6 (-10); ready_i toggles 1,0,0,1 → data_o/valid_o stable while ready_i=0. w1 = 0xFFFFFFF6 unchanged. No word duplicated or dropped.
- Latency: READ_LATENCY=2, ready_i=1, N=2 → first valid_o 4 cycles after leaving IDLE. Records spaced 9 cycles.
- Flush empty: enable_i=1, used_i=0, flush_i pulse → no valid_o, clear_o one cycle later, busy_o returns low.
- Retrigger guard: full_flag_i held high for 20 cycles after clear_o → block stays in RELEASE with no second pass. It returns to IDLE when full_flag_i falls. flush_i pulsed during the pass is ignored.
- Reset mid-pass: assert resetn_i low during SEND of record 1 of 4 → valid_o, clear_o, busy_o and records_o go 0 immediately (asynchronous). No clear_o pulse occurs afterwards.

Source files
------------

// File: rtl/sampler_buffer_drain.sv
// Drains the lease sampler's reuse-interval buffer: reads records 0..N-1, streams each
// as five 32b words on a valid/ready port, then pulses clear_o to release the stalled core.
module sampler_buffer_drain #(
  parameter int BUF_AW       = 13,
  parameter int BUF_DEPTH    = 8192,
  parameter int READ_LATENCY = 2
) (
  input  logic              clock_i,
  input  logic              resetn_i,
  input  logic              enable_i,
  input  logic              full_flag_i,
  input  logic              flush_i,
  input  logic [31:0]       used_i,
  output logic [BUF_AW-1:0] buf_addr_o,
  input  logic [31:0]       ref_address_i,
  input  logic [31:0]       ref_interval_i,
  input  logic [63:0]       ref_trace_i,
  input  logic [31:0]       ref_target_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o,
  output logic              clear_o,
  output logic              busy_o,
  output logic [31:0]       records_o
);

  // One extra index bit so a full BUF_DEPTH pass never wraps.
  localparam int               IDX_W     = BUF_AW + 1;
  localparam logic [31:0]      DEPTH32   = 32'(BUF_DEPTH);
  localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(BUF_DEPTH);
  localparam logic [1:0]       LAT_INIT  = 2'(READ_LATENCY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_WAIT,
    S_SEND,
    S_CLEAR,
    S_RELEASE
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   recCount_q, recCount_d;
  logic [IDX_W-1:0]   recIndex_q, recIndex_d;
  logic [1:0]         latCnt_q, latCnt_d;
  logic [2:0]         word_q, word_d;
  logic [BUF_AW-1:0]  bufAddr_q, bufAddr_d;
  logic [31:0]        holdAddr_q, holdAddr_d;
  logic [31:0]        holdInterval_q, holdInterval_d;
  logic [63:0]        holdTrace_q, holdTrace_d;
  logic [31:0]        holdTarget_q, holdTarget_d;
  logic [31:0]        records_q, records_d;

  logic [IDX_W-1:0]   nClamp;
  logic [IDX_W-1:0]   idxNext;
  logic               lastRec;
  logic [31:0]        dataSel;

  assign nClamp  = (used_i > DEPTH32) ? DEPTH_IDX : used_i[IDX_W-1:0];
  assign idxNext = recIndex_q + IDX_W'(1);
  assign lastRec = (idxNext == recCount_q);

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q        <= S_IDLE;
      recCount_q     <= '0;
      recIndex_q     <= '0;
      latCnt_q       <= '0;
      word_q         <= '0;
      bufAddr_q      <= '0;
      holdAddr_q     <= '0;
      holdInterval_q <= '0;
      holdTrace_q    <= '0;
      holdTarget_q   <= '0;
      records_q      <= '0;
    end else begin
      state_q        <= state_d;
      recCount_q     <= recCount_d;
      recIndex_q     <= recIndex_d;
      latCnt_q       <= latCnt_d;
      word_q         <= word_d;
      bufAddr_q      <= bufAddr_d;
      holdAddr_q     <= holdAddr_d;
      holdInterval_q <= holdInterval_d;
      holdTrace_q    <= holdTrace_d;
      holdTarget_q   <= holdTarget_d;
      records_q      <= records_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    recCount_d     = recCount_q;
    recIndex_d     = recIndex_q;
    latCnt_d       = latCnt_q;
    word_d         = word_q;
    bufAddr_d      = bufAddr_q;
    holdAddr_d     = holdAddr_q;
    holdInterval_d = holdInterval_q;
    holdTrace_d    = holdTrace_q;
    holdTarget_d   = holdTarget_q;
    records_d      = records_q;

    case (state_q)
      S_IDLE: begin
        if (enable_i && (full_flag_i || flush_i)) begin
          recCount_d = nClamp;
          recIndex_d = '0;
          state_d    = (nClamp == '0) ? S_CLEAR : S_ADDR;
        end
      end
      S_ADDR: begin
        bufAddr_d = recIndex_q[BUF_AW-1:0];
        latCnt_d  = LAT_INIT;
        state_d   = S_WAIT;
      end
      // The address register updates on leaving ADDR, so the count reaching zero
      // lands exactly READ_LATENCY cycles after the buffer saw the new address.
      S_WAIT: begin
        if (latCnt_q == 2'd0) begin
          holdAddr_d     = ref_address_i;
          holdInterval_d = ref_interval_i;
          holdTrace_d    = ref_trace_i;
          holdTarget_d   = ref_target_i;
          word_d         = 3'd0;
          state_d        = S_SEND;
        end else begin
          latCnt_d = latCnt_q - 2'd1;
        end
      end
      S_SEND: begin
        if (ready_i) begin
          if (word_q == 3'd4) begin
            if (records_q != 32'hFFFF_FFFF) begin
              records_d = records_q + 32'd1;
            end
            if (lastRec) begin
              state_d = S_CLEAR;
            end else begin
              recIndex_d = idxNext;
              state_d    = S_ADDR;
            end
          end else begin
            word_d = word_q + 3'd1;
          end
        end
      end
      S_CLEAR: begin
        state_d = S_RELEASE;
      end
      // Hold here while the full level is still up so a stale level cannot start a second pass.
      S_RELEASE: begin
        if (!full_flag_i) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    dataSel = '0;
    if (state_q == S_SEND) begin
      case (word_q)
        3'd0:    dataSel = holdAddr_q;
        3'd1:    dataSel = holdInterval_q;
        3'd2:    dataSel = holdTrace_q[31:0];
        3'd3:    dataSel = holdTrace_q[63:32];
        default: dataSel = holdTarget_q;
      endcase
    end
  end

  assign buf_addr_o = bufAddr_q;
  assign data_o     = dataSel;
  assign valid_o    = (state_q == S_SEND);
  assign last_o     = (state_q == S_SEND) && (word_q == 3'd4) && lastRec;
  assign clear_o    = (state_q == S_CLEAR);
  assign busy_o     = (state_q != S_IDLE);
  assign records_o  = records_q;

endmodule
